// File: rtl/coll_pkg.sv
// Shared definitions for the collision pulse generator: channel state
// encoding and default synchronizer/debounce depths.
package coll_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 5;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ARMING,
        CH_PRESSED,
        CH_RELEASING
    } chan_state_t;

endpackage

// File: rtl/coll_debounce_chan.sv
// One debounce channel: synchronizer chain, 4-state press/release FSM with
// a saturating stability counter, and a registered one-cycle pulse request
// raised on the ARMING -> PRESSED transition.
module coll_debounce_chan
    import coll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic nRst,
    input  logic raw_i,
    output logic req_o,
    output logic busy_o
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    chan_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   req_q, req_d;

    // Synchronizer chain for the asynchronous raw input
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // FSM state, stability counter and pulse request registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic; the counter is cleared on reaching the threshold so it never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        cnt_inc = cnt_q + CNT_ONE;
        unique case (state_q)
            CH_IDLE: begin
                if (synced) begin
                    state_d = CH_ARMING;
                    cnt_d   = CNT_ONE;
                end
            end
            CH_ARMING: begin
                if (!synced) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = CH_PRESSED;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CH_PRESSED: begin
                if (!synced) begin
                    state_d = CH_RELEASING;
                    cnt_d   = CNT_ONE;
                end
            end
            CH_RELEASING: begin
                if (synced) begin
                    state_d = CH_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign req_o  = req_q;
    assign busy_o = (state_q != CH_IDLE);

endmodule

// File: rtl/coll_pulse_gen.sv
// Collision pulse generator: two debounced channels feeding registered
// one-cycle pulses to the score stage. Good wins a same-cycle tie and the
// bad pulse is held pending for one cycle; gameComplete suppresses output.
module coll_pulse_gen
    import coll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic nRst,
    input  logic goodRaw,
    input  logic badRaw,
    input  logic gameComplete,
    output logic goodColl,
    output logic badColl,
    output logic busy
);

    logic good_req, bad_req;
    logic good_busy, bad_busy;
    logic goodColl_q, goodColl_d;
    logic badColl_q, badColl_d;
    logic pend_q, pend_d;

    coll_debounce_chan #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_good_chan (
        .clk    (clk),
        .nRst   (nRst),
        .raw_i  (goodRaw),
        .req_o  (good_req),
        .busy_o (good_busy)
    );

    coll_debounce_chan #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bad_chan (
        .clk    (clk),
        .nRst   (nRst),
        .raw_i  (badRaw),
        .req_o  (bad_req),
        .busy_o (bad_busy)
    );

    // Arbitration: good first, bad deferred one cycle on a tie, all dropped at game over
    always_comb begin
        goodColl_d = 1'b0;
        badColl_d  = 1'b0;
        pend_d     = pend_q;
        if (gameComplete) begin
            pend_d = 1'b0;
        end else if (good_req) begin
            goodColl_d = 1'b1;
            pend_d     = pend_q | bad_req;
        end else if (pend_q) begin
            badColl_d = 1'b1;
            pend_d    = bad_req;
        end else if (bad_req) begin
            badColl_d = 1'b1;
        end
    end

    // Output pulse and pending-flag registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            goodColl_q <= 1'b0;
            badColl_q  <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            goodColl_q <= goodColl_d;
            badColl_q  <= badColl_d;
            pend_q     <= pend_d;
        end
    end

    assign goodColl = goodColl_q;
    assign badColl  = badColl_q;
    assign busy     = good_busy | bad_busy | pend_q;

endmodule

// File: tb/tb_coll_pulse_gen.sv
// Bench for coll_pulse_gen at default parameters (2 sync stages, 5-sample
// debounce). Stimulus pushes the expected pulse kind and cycle into a
// scoreboard; a negedge monitor pops and compares every pulse it sees.
module tb_coll_pulse_gen;

    localparam int unsigned LAT = 2 + 5 + 1;  // stimulus negedge -> pulse-visible negedge

    typedef struct {
        bit          is_bad;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic nRst;
    logic goodRaw, badRaw, gameComplete;
    logic goodColl, badColl, busy;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    coll_pulse_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (5)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .goodRaw      (goodRaw),
        .badRaw       (badRaw),
        .gameComplete (gameComplete),
        .goodColl     (goodColl),
        .badColl      (badColl),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input bit is_bad, input int unsigned at);
        exp_t e;
        e.is_bad = is_bad;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    // Monitor: every visible pulse is matched against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (goodColl || badColl) begin
            n_checks++;
            if (goodColl && badColl) begin
                n_fail++;
                $display("FAIL overlap: goodColl=1 badColl=1 at cycle %0d, expected at most one high", cyc);
            end
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: good=%0b bad=%0b at cycle %0d, expected none", goodColl, badColl, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind_is_bad", int'(badColl), int'(e.is_bad));
                check("pulse_cycle", int'(cyc), int'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        nRst = 1'b0;
        goodRaw = 1'b0;
        badRaw = 1'b0;
        gameComplete = 1'b0;
        wait_neg(2);
        check("reset_goodColl", int'(goodColl), 0);
        check("reset_badColl", int'(badColl), 0);
        check("reset_busy", int'(busy), 0);
        nRst = 1'b1;
        wait_neg(2);

        // Clean good press held 20 cycles; busy falls exactly at end of release debounce
        t0 = cyc;
        goodRaw = 1'b1;
        expect_pulse(1'b0, t0 + LAT);
        wait_neg(3);
        check("busy_during_press", int'(busy), 1);
        wait_neg(17);
        goodRaw = 1'b0;
        wait_neg(6);
        check("busy_before_release_done", int'(busy), 1);
        wait_neg(1);
        check("busy_after_release_done", int'(busy), 0);
        wait_neg(8);

        // Short bounces never reach the threshold
        goodRaw = 1'b1;
        wait_neg(3);
        goodRaw = 1'b0;
        wait_neg(3);
        goodRaw = 1'b1;
        wait_neg(3);
        goodRaw = 1'b0;
        wait_neg(15);
        check("bounce_idle_busy", int'(busy), 0);

        // Bad press alone
        t0 = cyc;
        badRaw = 1'b1;
        expect_pulse(1'b1, t0 + LAT);
        wait_neg(10);
        badRaw = 1'b0;
        wait_neg(15);

        // Simultaneous presses: good first, bad one cycle later
        t0 = cyc;
        goodRaw = 1'b1;
        badRaw = 1'b1;
        expect_pulse(1'b0, t0 + LAT);
        expect_pulse(1'b1, t0 + LAT + 1);
        wait_neg(20);
        goodRaw = 1'b0;
        badRaw = 1'b0;
        wait_neg(15);
        check("tie_idle_busy", int'(busy), 0);

        // gameComplete suppresses a bad press; dropping it mid-hold does not revive the pulse
        gameComplete = 1'b1;
        badRaw = 1'b1;
        wait_neg(12);
        check("gc_fsm_tracks_busy", int'(busy), 1);
        gameComplete = 1'b0;
        wait_neg(8);
        badRaw = 1'b0;
        wait_neg(15);

        // Pending bad pulse discarded when gameComplete rises in its slot
        t0 = cyc;
        goodRaw = 1'b1;
        badRaw = 1'b1;
        expect_pulse(1'b0, t0 + LAT);
        wait_neg(LAT);
        gameComplete = 1'b1;
        wait_neg(1);
        gameComplete = 1'b0;
        wait_neg(11);
        goodRaw = 1'b0;
        badRaw = 1'b0;
        wait_neg(15);

        // Asynchronous reset mid-press: needs a full interval after release
        goodRaw = 1'b1;
        wait_neg(4);
        check("busy_before_reset", int'(busy), 1);
        #2;
        nRst = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_goodColl", int'(goodColl), 0);
        check("async_reset_badColl", int'(badColl), 0);
        @(negedge clk);
        nRst = 1'b1;
        t0 = cyc;
        expect_pulse(1'b0, t0 + LAT);
        wait_neg(20);
        goodRaw = 1'b0;
        wait_neg(15);

        // Release bounce inside RELEASING yields a single pulse
        t0 = cyc;
        goodRaw = 1'b1;
        expect_pulse(1'b0, t0 + LAT);
        wait_neg(10);
        goodRaw = 1'b0;
        wait_neg(2);
        goodRaw = 1'b1;
        wait_neg(10);
        goodRaw = 1'b0;
        wait_neg(15);
        check("final_idle_busy", int'(busy), 0);

        wait_neg(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
